rst_req_gen: RTL and testbench



---
 rtl/rst_pkg.sv | 22 ++
 rtl/rst_debounce.sv | 49 ++++
 rtl/rst_req_gen.sv | 121 ++++++++++++
 tb/tb_rst_req_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types for the reset-request generator.
// State encoding, cause codes and a small sizing helper.
package rst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ASSERT  = 2'b01,
      ST_RELEASE = 2'b10,
      ST_FINISH  = 2'b11
   } state_e;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_EXT = 2'b10;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rst_debounce.sv
// External reset button filter: fires once per sustained low press.
// Counter saturates; re-arms only after a high sample.
module rst_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic EXT_RST_N,
   output logic EXT_TRIG
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;

   // Count consecutive low samples; trigger on the one that reaches the threshold.
   always_comb begin
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      EXT_TRIG = 1'b0;
      if (EXT_RST_N) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else begin
         if (cnt_q != D_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (armed_q && cnt_q == D_LAST) begin
            EXT_TRIG = 1'b1;
            armed_d  = 1'b0;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/rst_req_gen.sv
// Reset-request generator: merges power-on, software and button resets
// into one stretched active-low reset with a release settle window.
module rst_req_gen
   import rst_pkg::*;
#(
   parameter int ASSERT_CYCLES   = 16,
   parameter int RELEASE_CYCLES  = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SW_REQ,
   input  logic       EXT_RST_N,
   output logic       RST_OUT_N,
   output logic       BUSY,
   output logic       DONE,
   output logic [1:0] CAUSE
);

   localparam int CW = $clog2(
      max3(ASSERT_CYCLES, RELEASE_CYCLES, DEBOUNCE_CYCLES) + 1);
   localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
   localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cause_q, cause_d;
   logic          rst_out_n_q, rst_out_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ext_trig;
   logic          trig;
   logic [1:0]    trig_cause;

   rst_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK      (CLK),
      .RST      (RST),
      .EXT_RST_N(EXT_RST_N),
      .EXT_TRIG (ext_trig)
   );

   assign trig       = SW_REQ | ext_trig;
   assign trig_cause = ext_trig ? CAUSE_EXT : CAUSE_SW;

   // Sequencer next state; any trigger outside FINISH (re)starts the low phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               cause_d = trig_cause;
            end
         end
         ST_ASSERT: begin
            if (trig) begin
               cnt_d   = '0;
               cause_d = trig_cause;
            end else if (cnt_q == A_LAST) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (trig) begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               cause_d = trig_cause;
            end else if (cnt_q == R_LAST) begin
               state_d = ST_FINISH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
         end
      endcase
      rst_out_n_d = (state_d != ST_ASSERT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_FINISH);
   end

   // State, counter, cause and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_ASSERT;
         cnt_q       <= '0;
         cause_q     <= CAUSE_POR;
         rst_out_n_q <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         rst_out_n_q <= rst_out_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign RST_OUT_N = rst_out_n_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign CAUSE     = cause_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: timestamp reference model checked every cycle,
// directed scenarios with literal expectations, then random stimulus.
module tb_rst_req_gen;

   localparam int A = 16;
   localparam int R = 4;
   localparam int D = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SW_REQ = 1'b0;
   logic       EXT_RST_N = 1'b1;
   logic       RST_OUT_N;
   logic       BUSY;
   logic       DONE;
   logic [1:0] CAUSE;

   int n_vec = 0;
   int n_err = 0;

   rst_req_gen #(
      .ASSERT_CYCLES  (A),
      .RELEASE_CYCLES (R),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SW_REQ   (SW_REQ),
      .EXT_RST_N(EXT_RST_N),
      .RST_OUT_N(RST_OUT_N),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .CAUSE    (CAUSE)
   );

   always #5 CLK = ~CLK;

   // Reference model: everything follows from the edge of the latest
   // accepted trigger (t_trig) and the run length of low button samples.
   int         n = 0;
   int         t_trig = 0;
   int         lowrun = 0;
   bit         valid = 0;
   logic [1:0] m_cause = 2'b00;

   always @(posedge CLK) begin
      bit fire;
      n++;
      if (RST) begin
         t_trig = n;
         m_cause = 2'b00;
         lowrun = 0;
         valid = 1;
      end else if (valid) begin
         fire = !EXT_RST_N && (lowrun + 1 == D);
         lowrun = EXT_RST_N ? 0 : lowrun + 1;
         // a trigger is ignored only in the single DONE cycle
         if ((SW_REQ || fire) && (n - 1 - t_trig) != A + R) begin
            t_trig = n;
            m_cause = fire ? 2'b10 : 2'b01;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge CLK) begin
      int age;
      logic e_rst, e_busy, e_done;
      if (valid) begin
         age = n - t_trig;
         e_rst  = (age >= A);
         e_busy = (age <= A + R);
         e_done = (age == A + R);
         n_vec++;
         if (RST_OUT_N !== e_rst || BUSY !== e_busy ||
             DONE !== e_done || CAUSE !== m_cause) begin
            n_err++;
            $display("FAIL cycle%0d: got rst_n=%b busy=%b done=%b cause=%b, want %b %b %b %b",
                     n, RST_OUT_N, BUSY, DONE, CAUSE,
                     e_rst, e_busy, e_done, m_cause);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic e);
      #1;
      RST = r;
      SW_REQ = s;
      EXT_RST_N = e;
      @(negedge CLK);
   endtask

   // Run a scenario from idle and tally low / release / done observations.
   task automatic measure(input int sw0, input int sw1, input int ef,
                          input int et, input int rat, input string nm,
                          output int lows, output int rels, output int dones);
      int i;
      lows = 0;
      rels = 0;
      dones = 0;
      i = 0;
      while (i < 400) begin
         step(i == rat, (i == sw0) || (i == sw1), !(i >= ef && i < et));
         if (!RST_OUT_N) lows++;
         else if (DONE) dones++;
         else if (BUSY) rels++;
         i++;
         if (i >= et && i > rat && i > sw1 && i > sw0 && !BUSY) break;
      end
      chk({nm, "_settle"}, int'(i < 400), 1);
   endtask

   initial begin
      int lo, rl, dn, busy_seen, run;
      logic ev;

      // power-on
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 0, 1);
      chk("por_rst_n", RST_OUT_N, 0);
      chk("por_busy", BUSY, 1);
      measure(-1, -1, -1, -1, -1, "por", lo, rl, dn);
      chk("por_low", lo + 1, 16);
      chk("por_rel", rl, 4);
      chk("por_done", dn, 1);
      chk("por_cause", CAUSE, 0);

      // software pulse
      measure(0, -1, -1, -1, -1, "sw", lo, rl, dn);
      chk("sw_low", lo, 16);
      chk("sw_rel", rl, 4);
      chk("sw_done", dn, 1);
      chk("sw_cause", CAUSE, 1);

      // bounce: 5 low, 1 high, 5 low
      busy_seen = 0;
      for (int i = 0; i < 14; i++) begin
         step(0, 0, !(i < 5 || (i >= 6 && i < 11)));
         if (BUSY) busy_seen++;
      end
      chk("bounce_busy", busy_seen, 0);

      // 8 consecutive lows
      measure(-1, -1, 0, 8, -1, "ext8", lo, rl, dn);
      chk("ext8_low", lo, 16);
      chk("ext8_done", dn, 1);
      chk("ext8_cause", CAUSE, 2);

      // held low for 100 cycles
      measure(-1, -1, 0, 100, -1, "hold", lo, rl, dn);
      chk("hold_done", dn, 1);
      chk("hold_low", lo, 16);

      // extension: second pulse at ASSERT cnt=10
      measure(0, 11, -1, -1, -1, "extend", lo, rl, dn);
      chk("extend_low", lo, 27);
      chk("extend_done", dn, 1);

      // abort: second pulse at RELEASE cnt=2
      measure(0, 19, -1, -1, -1, "abort", lo, rl, dn);
      chk("abort_low", lo, 32);
      chk("abort_rel", rl, 7);
      chk("abort_done", dn, 1);
      chk("abort_cause", CAUSE, 1);

      // software pulse coincident with the 8th low sample
      measure(7, -1, 0, 8, -1, "simul", lo, rl, dn);
      chk("simul_low", lo, 16);
      chk("simul_done", dn, 1);
      chk("simul_cause", CAUSE, 2);

      // RST during RELEASE
      measure(0, -1, -1, -1, 17, "midrst", lo, rl, dn);
      chk("midrst_low", lo, 32);
      chk("midrst_rel", rl, 5);
      chk("midrst_done", dn, 1);
      chk("midrst_cause", CAUSE, 0);

      // random traffic
      run = 0;
      ev = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (run == 0) begin
            ev = ~ev;
            run = ev ? $urandom_range(1, 30) : $urandom_range(1, 12);
         end
         run--;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, ev);
      end
      step(0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
